// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one lower-level cache port between two requesters.
// One transaction in flight; read fills are matched by block address and routed back.
module cache_port_arbiter #(
  parameter int ADDR_BITS = 64,
  parameter int B         = 64,
  parameter int DROP_W    = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 r0_valid_in,
  output logic                 r0_ready_out,
  input  logic [ADDR_BITS-1:0] r0_addr_in,
  input  logic                 r0_we_in,
  input  logic [B*8-1:0]       r0_line_in,
  output logic                 r0_valid_out,
  input  logic                 r0_ready_in,
  output logic [ADDR_BITS-1:0] r0_addr_out,
  output logic [B*8-1:0]       r0_line_out,
  input  logic                 r1_valid_in,
  output logic                 r1_ready_out,
  input  logic [ADDR_BITS-1:0] r1_addr_in,
  input  logic                 r1_we_in,
  input  logic [B*8-1:0]       r1_line_in,
  output logic                 r1_valid_out,
  input  logic                 r1_ready_in,
  output logic [ADDR_BITS-1:0] r1_addr_out,
  output logic [B*8-1:0]       r1_line_out,
  output logic                 lc_valid_out,
  input  logic                 lc_ready_in,
  output logic [ADDR_BITS-1:0] lc_addr_out,
  output logic                 lc_we_out,
  output logic [B*8-1:0]       lc_line_out,
  input  logic                 lc_valid_in,
  output logic                 lc_ready_out,
  input  logic [ADDR_BITS-1:0] lc_addr_in,
  input  logic [B*8-1:0]       lc_line_in,
  output logic                 busy_out,
  output logic                 grant_out,
  output logic [DROP_W-1:0]    drop_cnt_out
);

  localparam int OFF = $clog2(B);
  localparam logic [ADDR_BITS-1:0] BLK_MASK = {ADDR_BITS{1'b1}} << OFF;

  // state | meaning
  // IDLE  | arbitrate and accept one request
  // ISSUE | present request to lower level
  // WAIT  | read outstanding, consume fills until block address matches
  // RESP  | present fill to the issuing requester
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   req_addr_q, req_addr_d;
  logic                   req_we_q, req_we_d;
  logic [B*8-1:0]         req_line_q, req_line_d;
  logic                   req_id_q, req_id_d;
  logic [B*8-1:0]         resp_line_q, resp_line_d;
  logic                   rr_ptr_q, rr_ptr_d;
  logic [DROP_W-1:0]      drop_cnt_q, drop_cnt_d;
  logic                   winner;
  logic                   fill_match;

  assign winner     = (r0_valid_in && r1_valid_in) ? rr_ptr_q : r1_valid_in;
  assign fill_match = (lc_addr_in & BLK_MASK) == (req_addr_q & BLK_MASK);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      req_addr_q  <= '0;
      req_we_q    <= 1'b0;
      req_line_q  <= '0;
      req_id_q    <= 1'b0;
      resp_line_q <= '0;
      rr_ptr_q    <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_we_q    <= req_we_d;
      req_line_q  <= req_line_d;
      req_id_q    <= req_id_d;
      resp_line_q <= resp_line_d;
      rr_ptr_q    <= rr_ptr_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    req_we_d     = req_we_q;
    req_line_d   = req_line_q;
    req_id_d     = req_id_q;
    resp_line_d  = resp_line_q;
    rr_ptr_d     = rr_ptr_q;
    drop_cnt_d   = drop_cnt_q;
    r0_ready_out = 1'b0;
    r1_ready_out = 1'b0;
    lc_ready_out = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (r0_valid_in || r1_valid_in) begin
          r0_ready_out = ~winner;
          r1_ready_out = winner;
          req_addr_d   = winner ? r1_addr_in : r0_addr_in;
          req_we_d     = winner ? r1_we_in   : r0_we_in;
          req_line_d   = winner ? r1_line_in : r0_line_in;
          req_id_d     = winner;
          rr_ptr_d     = ~winner;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (lc_ready_in) state_d = req_we_q ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        lc_ready_out = 1'b1;
        if (lc_valid_in) begin
          if (fill_match) begin
            resp_line_d = lc_line_in;
            state_d     = S_RESP;
          end else if (drop_cnt_q != {DROP_W{1'b1}}) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
          end
        end
      end
      S_RESP: begin
        if (req_id_q ? r1_ready_in : r0_ready_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Response and lower-level outputs are zero outside their owning state.
  assign r0_valid_out = (state_q == S_RESP) && !req_id_q;
  assign r1_valid_out = (state_q == S_RESP) &&  req_id_q;
  assign r0_addr_out  = r0_valid_out ? req_addr_q  : '0;
  assign r1_addr_out  = r1_valid_out ? req_addr_q  : '0;
  assign r0_line_out  = r0_valid_out ? resp_line_q : '0;
  assign r1_line_out  = r1_valid_out ? resp_line_q : '0;

  assign lc_valid_out = (state_q == S_ISSUE);
  assign lc_addr_out  = lc_valid_out ? (req_addr_q & BLK_MASK) : '0;
  assign lc_we_out    = lc_valid_out && req_we_q;
  assign lc_line_out  = lc_we_out ? req_line_q : '0;

  assign busy_out     = (state_q != S_IDLE);
  assign grant_out    = req_id_q;
  assign drop_cnt_out = drop_cnt_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: directed scenarios then random traffic,
// checked against a transaction-level model of arbitration, routing and drop counting.
module tb_cache_port_arbiter;

  logic             clk, rst;
  logic [1:0]       r_valid, r_we, r_rdy_in, r_rdy_o, rv_o;
  logic [1:0][63:0]  r_addr, ra_o;
  logic [1:0][511:0] r_line, rl_o;
  logic             lc_ready_in, lc_valid_in, lc_valid_o, lc_we_o, lc_ready_o;
  logic [63:0]      lc_addr_in, lc_addr_o;
  logic [511:0]     lc_line_in, lc_line_o;
  logic             busy_o, grant_o;
  logic [7:0]       drop_o;

  int checks = 0;
  int failures = 0;
  int rr_m = 0;
  int drop_m = 0;

  cache_port_arbiter dut (
    .clk_in(clk), .rst_in(rst),
    .r0_valid_in(r_valid[0]), .r0_ready_out(r_rdy_o[0]), .r0_addr_in(r_addr[0]),
    .r0_we_in(r_we[0]), .r0_line_in(r_line[0]), .r0_valid_out(rv_o[0]),
    .r0_ready_in(r_rdy_in[0]), .r0_addr_out(ra_o[0]), .r0_line_out(rl_o[0]),
    .r1_valid_in(r_valid[1]), .r1_ready_out(r_rdy_o[1]), .r1_addr_in(r_addr[1]),
    .r1_we_in(r_we[1]), .r1_line_in(r_line[1]), .r1_valid_out(rv_o[1]),
    .r1_ready_in(r_rdy_in[1]), .r1_addr_out(ra_o[1]), .r1_line_out(rl_o[1]),
    .lc_valid_out(lc_valid_o), .lc_ready_in(lc_ready_in), .lc_addr_out(lc_addr_o),
    .lc_we_out(lc_we_o), .lc_line_out(lc_line_o), .lc_valid_in(lc_valid_in),
    .lc_ready_out(lc_ready_o), .lc_addr_in(lc_addr_in), .lc_line_in(lc_line_in),
    .busy_out(busy_o), .grant_out(grant_o), .drop_cnt_out(drop_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic set_req(input int k, input logic [63:0] a, input logic we, input logic [511:0] ln);
    r_valid[k] = 1'b1;
    r_addr[k]  = a;
    r_we[k]    = we;
    r_line[k]  = ln;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    r_valid = '0; r_rdy_in = '0; lc_ready_in = 1'b0; lc_valid_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rr_m = 0;
    drop_m = 0;
  endtask

  // One full transaction starting from IDLE at a negedge with requests already driven.
  task automatic run_txn(input int rdly, input int ndrop, input int respdly,
                         input logic [511:0] fline, input bit raise_other);
    int w, o;
    logic [63:0] a, blk;
    logic we;
    logic [511:0] ln, held;
    w   = (r_valid[0] && r_valid[1]) ? rr_m : (r_valid[1] ? 1 : 0);
    o   = 1 - w;
    a   = r_addr[w];
    we  = r_we[w];
    ln  = r_line[w];
    blk = a & ~64'h3F;
    #1;
    chk("idle_busy", busy_o, 0);
    chk("ready_winner", r_rdy_o[w], 1);
    chk("ready_other", r_rdy_o[o], 0);
    chk("idle_lc_ready", lc_ready_o, 0);
    @(negedge clk);
    rr_m = o;
    r_valid[w] = 1'b0;
    if (raise_other && !r_valid[o]) set_req(o, {$urandom, $urandom}, 1'($urandom), rand_line());
    #1;
    chk("grant", grant_o, w);
    chk("issue_busy", busy_o, 1);
    chk("issue_lc_valid", lc_valid_o, 1);
    chk("issue_lc_addr", lc_addr_o, blk);
    chk("issue_lc_we", lc_we_o, we);
    chk("issue_lc_line", lc_line_o, we ? ln : 512'h0);
    chk("issue_no_resp", rv_o, 0);
    chk("issue_readies", r_rdy_o, 0);
    lc_ready_in = 1'b0;
    repeat (rdly) begin
      @(negedge clk);
      chk("hold_lc_valid", lc_valid_o, 1);
      chk("hold_lc_addr", lc_addr_o, blk);
      chk("hold_lc_line", lc_line_o, we ? ln : 512'h0);
      chk("hold_readies", r_rdy_o, 0);
    end
    lc_ready_in = 1'b1;
    @(negedge clk);
    lc_ready_in = 1'b0;
    chk("post_issue_lc_valid", lc_valid_o, 0);
    if (we) begin
      chk("write_done_busy", busy_o, 0);
      chk("write_no_resp", rv_o, 0);
    end else begin
      chk("wait_busy", busy_o, 1);
      chk("wait_lc_ready", lc_ready_o, 1);
      for (int i = 0; i < ndrop; i++) begin
        lc_valid_in = 1'b1;
        lc_addr_in  = (i == 0) ? (blk ^ 64'h7000) : (blk + 64'h40 * (1 + $urandom_range(0, 1000)));
        lc_line_in  = rand_line();
        @(negedge clk);
        if (drop_m != 255) drop_m++;
        chk("drop_cnt", drop_o, drop_m);
        chk("drop_no_resp", rv_o, 0);
      end
      lc_valid_in = 1'b1;
      lc_addr_in  = blk | 64'($urandom_range(0, 63));
      lc_line_in  = fline;
      @(negedge clk);
      lc_valid_in = 1'b0;
      chk("resp_valid", rv_o, (w == 1) ? 2'b10 : 2'b01);
      chk("resp_addr", ra_o[w], a);
      chk("resp_line", rl_o[w], fline);
      held = rl_o[w];
      repeat (respdly) begin
        @(negedge clk);
        chk("resp_hold_valid", rv_o, (w == 1) ? 2'b10 : 2'b01);
        chk("resp_hold_line", rl_o[w], held);
        chk("resp_hold_readies", r_rdy_o, 0);
      end
      r_rdy_in[w] = 1'b1;
      @(negedge clk);
      r_rdy_in[w] = 1'b0;
      chk("resp_done_busy", busy_o, 0);
      chk("resp_done_valid", rv_o, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    r_valid = '0; r_we = '0; r_rdy_in = '0; r_addr = '0; r_line = '0;
    lc_ready_in = 1'b0; lc_valid_in = 1'b0; lc_addr_in = '0; lc_line_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_drop", drop_o, 0);
    chk("rst_resp_valid", rv_o, 0);
    chk("rst_lc_valid", lc_valid_o, 0);
    chk("rst_readies", r_rdy_o, 0);
    lc_valid_in = 1'b1; lc_addr_in = 64'h9000;
    #1;
    chk("idle_stray_fill_ready", lc_ready_o, 0);
    lc_valid_in = 1'b0;

    // Reset while waiting for a fill.
    @(negedge clk);
    set_req(0, 64'h5000, 1'b0, rand_line());
    @(negedge clk);
    r_valid[0] = 1'b0;
    lc_ready_in = 1'b1;
    @(negedge clk);
    lc_ready_in = 1'b0;
    lc_valid_in = 1'b1; lc_addr_in = 64'h9000;
    @(negedge clk);
    lc_valid_in = 1'b0;
    chk("pre_rst_drop", drop_o, 1);
    chk("pre_rst_busy", busy_o, 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_lc_ready", lc_ready_o, 0);
    chk("midrst_drop", drop_o, 0);
    @(negedge clk);
    rst = 1'b0;
    rr_m = 0; drop_m = 0;
    chk("postrst_resp", rv_o, 0);

    set_req(1, 64'h1040, 1'b0, rand_line());
    run_txn(0, 0, 0, rand_line(), 1'b0);
    set_req(0, 64'h1044, 1'b0, rand_line());
    run_txn(0, 0, 0, {64{8'hAB}}, 1'b0);

    // Both requesters valid from reset: strict alternation.
    do_reset();
    set_req(0, 64'h100 + 64'($urandom_range(0, 63)), 1'b0, rand_line());
    set_req(1, 64'h200 + 64'($urandom_range(0, 63)), 1'b0, rand_line());
    for (int i = 0; i < 8; i++) begin
      if (i > 0 && i < 7) begin
        for (int k = 0; k < 2; k++)
          if (!r_valid[k]) set_req(k, {$urandom, $urandom}, 1'b0, rand_line());
      end
      run_txn($urandom_range(0, 2), 0, $urandom_range(0, 2), rand_line(), 1'b0);
    end

    set_req(1, 64'h2000, 1'b1, {64{8'h55}});
    run_txn(3, 0, 0, rand_line(), 1'b0);

    do_reset();
    set_req(0, 64'h3000, 1'b0, rand_line());
    run_txn(0, 1, 0, rand_line(), 1'b0);
    chk("drop_one", drop_o, 1);
    set_req(0, 64'h3100, 1'b0, rand_line());
    run_txn(0, 300, 0, rand_line(), 1'b0);
    chk("drop_saturated", drop_o, 255);

    // Response stalled while r1 waits; r1 must win right after IDLE.
    set_req(0, 64'h6000, 1'b0, rand_line());
    run_txn(0, 0, 5, rand_line(), 1'b1);
    run_txn(0, 0, 0, rand_line(), 1'b0);

    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 2; k++)
        if (!r_valid[k] && $urandom_range(0, 1) == 1)
          set_req(k, {$urandom, $urandom}, 1'($urandom), rand_line());
      if (r_valid == 2'b00)
        set_req($urandom_range(0, 1), {$urandom, $urandom}, 1'($urandom), rand_line());
      run_txn($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3),
              rand_line(), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
